// File: rtl/fifo_sync_param.sv
// Single-clock parameterised FIFO with registered read data and count-derived status flags.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module fifo_sync_param #(
  parameter int DW       = 40,
  parameter int AW       = 9,
  parameter int AF_LEVEL = 480,
  parameter int AE_LEVEL = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_AF    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] LP_AE    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);

  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_dout;
  logic          r_full;
  logic          r_empty;
  logic          r_almost_full;
  logic          r_almost_empty;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [AW:0]   w_count_nxt;

  // A write into a full FIFO is only legal when a read frees the slot in the same cycle.
  assign w_wr_acc = ~clr & we & (~r_full | re);
  assign w_rd_acc = ~clr & re & ~r_empty;

  // Next occupancy; clear wins over any request.
  always_comb begin
    w_count_nxt = r_count;
    if (clr) begin
      w_count_nxt = '0;
    end else if (w_wr_acc & ~w_rd_acc) begin
      w_count_nxt = r_count + LP_ONE;
    end else if (w_rd_acc & ~w_wr_acc) begin
      w_count_nxt = r_count - LP_ONE;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Storage array: not reset, so clr and rst leave contents in place.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wp] <= din;
    end
  end

  // Pointers, occupancy, read data and status flags registered from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp           <= '0;
      r_rp           <= '0;
      r_count        <= '0;
      r_dout         <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == LP_DEPTH);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= LP_AF);
      r_almost_empty <= (w_count_nxt <= LP_AE);
      if (clr) begin
        r_wp <= '0;
        r_rp <= '0;
      end else begin
        if (w_wr_acc) begin
          r_wp <= r_wp + LP_PTR_ONE;
        end
        if (w_rd_acc) begin
          r_rp   <= r_rp + LP_PTR_ONE;
          r_dout <= r_mem[r_rp];
        end
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags, cleared only by rst or clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (we & r_full & ~re) begin
        r_overflow <= 1'b1;
      end
      if (re & r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end
`else
  assign r_overflow  = 1'b0;
  assign r_underflow = 1'b0;
`endif

  assign dout         = r_dout;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
